// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared loader state encoding and RAM direction constants.
package program_loader_pkg;
    localparam logic [2:0] LDR_IDLE    = 3'd0;
    localparam logic [2:0] LDR_HDR     = 3'd1;
    localparam logic [2:0] LDR_COLLECT = 3'd2;
    localparam logic [2:0] LDR_WRITE   = 3'd3;
    localparam logic [2:0] LDR_DONE    = 3'd4;
    localparam logic [2:0] LDR_ERR     = 3'd5;
    localparam logic MEM_WRITE = 1'b1;
    localparam logic MEM_READ  = 1'b0;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/program_loader_byte_packer.sv
// byte_packer: shifts accepted bytes MSB-first into a word, flags the completing byte.
module byte_packer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              accept_i,
    input  logic [7:0]        data_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_valid_o
);
    import program_loader_pkg::*;
    logic [DATA_W-9:0] shift_q, shift_d;
    logic [1:0]        cnt_q, cnt_d;
    assign word_o       = {shift_q, data_i};
    assign word_valid_o = accept_i && cnt_q == 2'(BYTES_PER_WORD - 1);
    always_comb begin
        shift_d = accept_i ? word_o[DATA_W-9:0] : shift_q;
        cnt_d   = clr_i ? 2'd0 : accept_i ? cnt_q + 2'd1 : cnt_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: loads a length-prefixed byte stream into RAM as big-endian words,
// holding the CPU until the load completes.
module program_loader #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rw,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);
    import program_loader_pkg::*;
    localparam int IDX_W = $clog2(MAX_WORDS + 1);
    logic [2:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d, n_q, n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, word;
    logic              accept, rearm, word_valid, hdr_acc;
    assign in_ready = state_q == LDR_HDR || state_q == LDR_COLLECT;
    assign accept   = in_valid && in_ready;
    assign hdr_acc  = accept && state_q == LDR_HDR;
    // start is honoured only between sessions; a load in flight cannot be restarted
    assign rearm    = start && (state_q == LDR_IDLE || state_q == LDR_DONE || state_q == LDR_ERR);
    assign mem_rw    = state_q == LDR_WRITE ? MEM_WRITE : MEM_READ;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_hold  = state_q != LDR_DONE;
    assign done      = state_q == LDR_DONE;
    assign error     = state_q == LDR_ERR;
    byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (rearm),
        .accept_i     (accept && state_q == LDR_COLLECT),
        .data_i       (in_data),
        .word_o       (word),
        .word_valid_o (word_valid)
    );
    always_comb begin
        state_d = state_q;
        if (rearm)
            state_d = LDR_HDR;
        else if (hdr_acc)
            state_d = in_data == 8'd0 ? LDR_DONE : in_data > 8'(MAX_WORDS) ? LDR_ERR : LDR_COLLECT;
        else if (word_valid)
            state_d = LDR_WRITE;
        else if (state_q == LDR_WRITE)
            state_d = idx_q + IDX_W'(1) == n_q ? LDR_DONE : LDR_COLLECT;
        idx_d   = rearm ? '0 : state_q == LDR_WRITE ? idx_q + IDX_W'(1) : idx_q;
        n_d     = hdr_acc ? in_data[IDX_W-1:0] : n_q;
        // address/data are captured with the completing byte so they are stable for the whole WRITE cycle
        addr_d  = word_valid ? ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q) : addr_q;
        wdata_d = word_valid ? word : wdata_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LDR_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized sessions checked against a queue-based load model.
module tb_program_loader;
    logic        clk = 0, rst = 0, start = 0, in_valid = 0;
    logic [7:0]  in_data = 0;
    logic        in_ready, mem_rw, cpu_hold, done, error;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    int n_checks = 0, n_fail = 0, cyc = 0;
    typedef struct { logic [15:0] a; logic [31:0] d; } wr_t;
    typedef logic [7:0] bq_t[$];
    wr_t wq[$];

    program_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_rw) begin
            wq.push_back('{mem_addr, mem_wdata});
            check("ready_in_write", in_ready, 0);
            check("hold_in_write", cpu_hold, 1);
        end
    end

    task automatic check_reset_outputs(string tag);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_rw"}, mem_rw, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_hold"}, cpu_hold, 1);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, error, 0);
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    // entered and left at a negedge; the byte is consumed by the posedge in between
    task automatic send_byte(logic [7:0] b, int gap);
        int k;
        repeat (gap) begin
            in_valid = 0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1;
        in_data  = b;
        for (k = 0; k < 50 && !in_ready; k++) @(negedge clk);
        if (!in_ready) check("send_timeout", in_ready, 1);
        @(negedge clk);
    endtask

    task automatic run_session(string tag, int n, int gap_max, int mid_at, bq_t data);
        bit   exp_err = n > 16;
        int   nb = exp_err ? 0 : 4 * n;
        int   t0, k, nw;
        logic [31:0] w;
        wq.delete();
        pulse_start();
        t0 = cyc;
        check({tag, "_rearm_hold"}, cpu_hold, 1);
        check({tag, "_rearm_done"}, done, 0);
        check({tag, "_rearm_err"}, error, 0);
        send_byte(8'(n), gap_max == 0 ? 0 : $urandom_range(0, gap_max));
        for (int i = 0; i < nb; i++) begin
            if (i == mid_at) begin
                in_valid = 0;
                pulse_start();
            end
            send_byte(data[i], gap_max == 0 ? 0 : $urandom_range(0, gap_max));
        end
        in_valid = 0;
        for (k = 0; k < 100 && !(done || error); k++) @(negedge clk);
        check({tag, "_finished"}, done || error, 1);
        if (gap_max == 0 && mid_at < 0)
            check({tag, "_latency"}, cyc - t0, exp_err ? 1 : 1 + 5 * n);
        check({tag, "_done"}, done, !exp_err);
        check({tag, "_error"}, error, exp_err);
        check({tag, "_hold"}, cpu_hold, exp_err);
        nw = exp_err ? 0 : n;
        check({tag, "_nwrites"}, wq.size(), nw);
        for (int i = 0; i < nw && i < wq.size(); i++) begin
            w = {data[4*i], data[4*i+1], data[4*i+2], data[4*i+3]};
            check($sformatf("%s_addr%0d", tag, i), wq[i].a, i);
            check($sformatf("%s_data%0d", tag, i), wq[i].d, w);
        end
        // bytes offered after completion must be ignored
        in_valid = 1;
        repeat (4) begin
            in_data = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 0;
        check({tag, "_idle_ready"}, in_ready, 0);
        check({tag, "_idle_writes"}, wq.size(), nw);
    endtask

    function automatic bq_t rand_bytes(int cnt);
        bq_t q;
        for (int i = 0; i < cnt; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    initial begin
        bq_t d;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("idle_ready", in_ready, 0);
        check("idle_hold", cpu_hold, 1);

        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_session("normal", 2, 0, -1, d);
        run_session("zero", 0, 0, -1, d);
        run_session("oversize", 17, 0, -1, d);
        d = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_session("after_err", 1, 0, -1, d);
        run_session("gaps", 3, 3, -1, rand_bytes(12));

        wq.delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'hDE, 1);
        send_byte(8'hAD, 0);
        in_valid = 0;
        rst = 0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("midrst_nowrite", wq.size(), 0);
        d = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
        run_session("after_rst", 1, 0, -1, d);

        run_session("mid_start", 2, 1, 5, rand_bytes(8));
        run_session("max_len", 16, 0, -1, rand_bytes(64));
        for (int s = 0; s < 10; s++)
            run_session($sformatf("rand%0d", s), $urandom_range(0, 18), $urandom_range(0, 2), -1, rand_bytes(72));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
